// File: rtl/ram_arbiter.sv
// Two-requester arbiter serializing single-word accesses onto a single-port RAM
// with registered reads; returns read data and a one-cycle ack to the winner.
module ram_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [1:0]            state_out
);

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } access_t;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  busy_q, busy_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

    logic    any_req_c;
    logic    grant_c;
    access_t sel_c;

    // Winner selection: sole requester wins; ties go by priority mode.
    always_comb begin
        any_req_c = req0 | req1;
        grant_c   = ~req0;
        if (req0 && req1) begin
            grant_c = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
        end
        sel_c.we    = we0;
        sel_c.addr  = addr0;
        sel_c.wdata = wdata0;
        if (grant_c) begin
            sel_c.we    = we1;
            sel_c.addr  = addr1;
            sel_c.wdata = wdata1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;

        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    state_d      = ISSUE;
                    owner_d      = grant_c;
                    last_grant_d = grant_c;
                    we_d         = sel_c.we;
                    ram_en_d     = 1'b1;
                    ram_we_d     = sel_c.we;
                    ram_addr_d   = sel_c.addr;
                    ram_wdata_d  = sel_c.wdata;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                state_d = DONE;
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                // RAM data is valid this cycle; capture lands alongside ack.
                if (!we_q) begin
                    if (owner_q) begin
                        rdata1_d = ram_rdata;
                    end else begin
                        rdata0_d = ram_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign busy      = busy_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign state_out = state_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single-port system RAM between the CPU memory path (MAR/MDR sequencing driven by the control unit) and a second bus master (program loader / DMA). It serializes one word access at a time through a small state machine and drives the RAM port. It returns read data and a one-cycle completion acknowledge to the winning requester. The RAM has registered reads: data appears one cycle after the enable.

## Interface
- ADDR_WIDTH, 8: RAM word-address width.
- DATA_WIDTH, 16: word width; matches the instruction/GPR width.
- FIXED_PRIORITY, 0: 0 selects round-robin; 1 makes requester 0 (CPU) always win ties.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request from CPU / loader; level, held until ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req high.
- addr0 / addr1  in  ADDR_WIDTH  word address; stable while req high.
- wdata0 / wdata1  in  DATA_WIDTH  write data; stable while req high.
- ack0 / ack1  out  1  one-cycle pulse marking access complete.
- rdata0 / rdata1  out  DATA_WIDTH  read result; valid with ack, held until that requester's next read completes.
- busy  out  1  high in any state other than IDLE.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable, qualified by ram_en.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en with ram_we low.
- state_out  out  2  current state, for debug display.

## Operation
- States (encoding): IDLE=0, ISSUE=1, WAIT=2, DONE=3.
- **IDLE**
  - No request high: stay in IDLE.
  - Request present: pick the winner, latch its owner, we, addr and wdata into internal registers, go to ISSUE.
- **Winner selection**
  - Only one request high: that requester wins.
  - Both high, FIXED_PRIORITY=1: requester 0 wins.
  - Both high, FIXED_PRIORITY=0: the requester not recorded in last_grant wins.
  - last_grant updates on every grant.
- **ISSUE**
  - Drive ram_en=1, ram_we=latched we, ram_addr=latched addr, ram_wdata=latched wdata.
  - Go to WAIT.
- **WAIT**
  - ram_en=0.
  - Latched read: capture ram_rdata into the owner's rdata register at the end of the cycle.
  - Latched write: rdata is untouched.
  - Go to DONE.
- **DONE**
  - Assert ack of the owner only; the other ack stays 0.
  - Go to IDLE.
- Requester rule: drop req (or present a new access) on the edge where its ack is high.
  - The following IDLE cycle samples the new req level.
  - req still high in that IDLE cycle is treated as a new access.
- Requests that appear or change outside IDLE are ignored until the next IDLE. The latched copies protect the in-flight access.
- The losing requester keeps req high and is served next, so no requester starves:
  - round-robin mode: guaranteed;
  - fixed mode: requester 1 starves only while requester 0 re-requests continuously.
- ram_we is 0 whenever ram_en is 0.

## Timing
- Latency: req high in IDLE at cycle N → ram_en at N+1 → read data captured at the end of N+2 → ack at N+3 → IDLE at N+4.
- Throughput: one access per 4 cycles.
- ack is derived from registered state only; no combinational path from req to ack.
- Reset (asserted low, asynchronous) forces, without waiting for a clock:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie), owner=0;
  - ack0=ack1=0, rdata0=rdata1=0, busy=0;
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, state_out=0.
- Reset mid-access: the in-flight access is abandoned with no ack. A write in ISSUE is cut off as ram_en drops immediately.
- First request is sampled on the first rising edge after reset deasserts.

## Test plan
- Single read: preload RAM[0x12]=0xBEEF; req0=1, we0=0, addr0=0x12 → ram_en high for exactly 1 cycle at N+1; ack0 at N+3 with rdata0=0xBEEF; ack1 stays 0.
- Single write: req1, we1=1, addr1=0x40, wdata1=0x1234 → ram_en=ram_we=1 at N+1 with addr 0x40 / data 0x1234; ack1 at N+3; rdata1 unchanged; a later read of 0x40 returns 0x1234.
- Round-robin tie (FIXED_PRIORITY=0): both requesters hold req continuously, each dropping req for one cycle after its ack → grants alternate 0,1,0,1 starting with 0; ack every 4 cycles.
- Fixed priority (FIXED_PRIORITY=1): req0 and req1 raised together → requester 0 served first, requester 1 at its ack+1; requester 1 ack at N+7.
- Mid-access change: change addr0 from 0x05 to 0x06 during ISSUE → ram_addr stays 0x05; returned data is RAM[0x05].
- Asynchronous reset: assert reset low in ISSUE, between clock edges → ram_en, busy and state_out go to 0 immediately; no ack; after release, a fresh req0 completes normally with 3-cycle latency.
